// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the uart transmitter and its front-end logic.
// The HOLDOFF minimum is one full uart txclk period, which returns the uart to IDLE.
package uart_pkg;

   localparam int unsigned UART_TXDIV  = 217;
   localparam int unsigned UART_CLK_HZ = 50_000_000;
   localparam int unsigned HOLDOFF_MIN = 2 * (UART_TXDIV + 1);

   localparam int unsigned CNT_W     = 12;
   localparam int unsigned CNT_RANGE = 1 << CNT_W;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_WAIT_BUSY = 4'b0010,
      ST_WAIT_DONE = 4'b0100,
      ST_HOLDOFF   = 4'b1000
   } arb_state_e;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
// Kept standalone so an RX-side distributor can reuse it.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [$clog2(NREQ)-1:0] gnt_idx_o,
   output logic                    any_o
);

   logic found;

   always_comb begin
      found     = 1'b0;
      gnt_idx_o = ptr_i;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr_i) + k) % NREQ;
         if (!found && req_i[idx]) begin
            found     = 1'b1;
            gnt_idx_o = $clog2(NREQ)'(idx);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NREQ byte producers, granting round-robin and
// sequencing the uart's level-sensitive wr/tbe handshake with a post-transfer hold-off.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned HOLDOFF_CYCLES = 440,
   parameter int unsigned TIMEOUT_CYCLES = 2048
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [8*NREQ-1:0]       req_data,
   output logic [NREQ-1:0]         req_ack,
   output logic [7:0]              uart_data,
   output logic                    uart_wr,
   input  logic                    uart_tbe,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    done,
   output logic                    timeout_err
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("uart_tx_arbiter: NREQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > CNT_RANGE) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES does not fit the 12-bit counter");
   end
   if (HOLDOFF_CYCLES < HOLDOFF_MIN || HOLDOFF_CYCLES > CNT_RANGE) begin : g_bad_holdoff
      $error("uart_tx_arbiter: HOLDOFF_CYCLES outside one uart txclk period .. counter range");
   end

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gid_q, gid_d;
   logic [7:0]       data_q, data_d;
   logic             wr_q, wr_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             done_q, done_d;
   logic             to_q, to_d;
   logic             tbe_meta_q, tbe_s_q;

   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic [7:0]       req_byte [NREQ];

   // tbe comes from the uart's slow txclk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbe_meta_q <= 1'b1;
         tbe_s_q    <= 1'b1;
      end else begin
         tbe_meta_q <= uart_tbe;
         tbe_s_q    <= tbe_meta_q;
      end
   end

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .gnt_idx_o(gnt_idx),
      .any_o    (gnt_any)
   );

   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         req_byte[k] = req_data[8*k +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      data_d  = data_q;
      wr_d    = wr_q;
      ack_d   = '0;
      done_d  = 1'b0;
      to_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               data_d         = req_byte[gnt_idx];
               ack_d[gnt_idx] = 1'b1;
               gid_d          = gnt_idx;
               wr_d           = 1'b1;
               cnt_d          = '0;
               state_d        = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (!tbe_s_q) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               wr_d    = 1'b0;
               to_d    = 1'b1;
               cnt_d   = '0;
               state_d = ST_HOLDOFF;
            end
         end
         ST_WAIT_DONE: begin
            if (tbe_s_q) begin
               wr_d    = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HOLDOFF_LAST) begin
               ptr_d   = IW'(wrap_inc(32'(gid_q), NREQ));
               state_d = ST_IDLE;
            end
         end
         default: begin
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gid_q   <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         ack_q   <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   assign req_ack     = ack_q;
   assign uart_data   = data_q;
   assign uart_wr     = wr_q;
   assign busy        = (state_q != ST_IDLE);
   assign grant_id    = gid_q;
   assign done        = done_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart model plus grant/byte scoreboards.
module tb_uart_tx_arbiter;

   localparam int HOLD = 440;
   localparam int TMO  = 2048;

   typedef struct {
      int         id;
      logic [7:0] data;
   } gnt_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ack;
   logic [7:0]  uart_data;
   logic        uart_wr;
   logic        uart_tbe;
   logic        busy;
   logic [1:0]  grant_id;
   logic        done;
   logic        timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   gnt_t       exp_gnt[$];
   logic [7:0] exp_rx[$];
   gnt_t       e;

   logic manual = 1'b0;
   logic man_tbe = 1'b1;

   int m_st, m_div, m_bit, m_bcnt;
   logic       m_tbe, m_txd;
   logic [9:0] m_sh, m_cap, last_frame;

   int lowcnt = 0;
   logic had_xfer = 1'b0;
   int done_cnt = 0;
   int to_cnt = 0;

   always #5 clk = ~clk;

   assign uart_tbe = manual ? man_tbe : m_tbe;

   uart_tx_arbiter #(
      .NREQ(4),
      .HOLDOFF_CYCLES(HOLD),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ack(req_ack),
      .uart_data(uart_data),
      .uart_wr(uart_wr),
      .uart_tbe(uart_tbe),
      .busy(busy),
      .grant_id(grant_id),
      .done(done),
      .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Uart model: samples wr on a slow tick, drops tbe, shifts 10 bits, waits for wr low.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; m_div <= 0; m_bit <= 0; m_bcnt <= 0;
         m_tbe <= 1'b1; m_txd <= 1'b1;
      end else if (!manual) begin
         m_div <= (m_div == 3) ? 0 : m_div + 1;
         case (m_st)
            0: if (m_div == 3 && uart_wr) begin
                  m_sh <= {1'b1, uart_data, 1'b0};
                  m_tbe <= 1'b0; m_txd <= 1'b0;
                  m_st <= 1; m_bit <= 0; m_bcnt <= 0;
               end
            1: begin
                  if (m_bcnt == 8) m_cap[m_bit] <= m_txd;
                  if (m_bcnt == 15) begin
                     m_bcnt <= 0;
                     if (m_bit == 9) begin
                        m_st <= 2; m_tbe <= 1'b1; m_txd <= 1'b1;
                        last_frame <= m_cap;
                        if (exp_rx.size() == 0) check("rx_unexpected", 32'(m_cap[8:1]), 32'hFFFF_FFFF);
                        else check("rx_byte", 32'(m_cap[8:1]), 32'(exp_rx.pop_front()));
                     end else begin
                        m_bit <= m_bit + 1;
                        m_txd <= m_sh[m_bit + 1];
                     end
                  end else m_bcnt <= m_bcnt + 1;
               end
            default: if (m_div == 3 && !uart_wr) m_st <= 0;
         endcase
      end
   end

   // Grant scoreboard and hold-off gap monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         lowcnt <= 0;
         had_xfer <= 1'b0;
      end else begin
         if (done) done_cnt <= done_cnt + 1;
         if (timeout_err) to_cnt <= to_cnt + 1;
         if (req_ack != '0) begin
            if (had_xfer) check("holdoff_gap", 32'(lowcnt >= HOLD), 1);
            if (exp_gnt.size() == 0) check("grant_unexpected", 32'(req_ack), 0);
            else begin
               e = exp_gnt.pop_front();
               check("req_ack", 32'(req_ack), 32'(1 << e.id));
               check("grant_id", 32'(grant_id), 32'(e.id));
               check("uart_data", 32'(uart_data), 32'(e.data));
               check("uart_wr_on_grant", 32'(uart_wr), 1);
            end
         end
         if (uart_wr) begin
            had_xfer <= 1'b1;
            lowcnt <= 0;
         end else lowcnt <= lowcnt + 1;
      end
   end

   function automatic logic cond(input int sel);
      case (sel)
         0: return req_ack != '0;
         1: return done;
         2: return !busy;
         3: return !uart_tbe;
         default: return timeout_err;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cond(sel) && n < budget);
      if (!cond(sel)) check({tag, "_timeout"}, 32'(n), 32'(budget + 1));
   endtask

   task automatic expect_grant(input int id, input logic [7:0] d, input logic rx);
      gnt_t g;
      g.id = id;
      g.data = d;
      exp_gnt.push_back(g);
      if (rx) exp_rx.push_back(d);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0, t0;
      logic wr_seen;
      int frame_ref[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      logic [9:0] frame_exp;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(req_ack), 0);
      check("rst_data", 32'(uart_data), 0);
      check("rst_wr", 32'(uart_wr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_gid", 32'(grant_id), 0);
      check("rst_done_to", 32'({done, timeout_err}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single request
      expect_grant(2, 8'hA5, 1'b1);
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      @(negedge clk);
      check("ack_latency", 32'(req_ack), 32'h4);
      req_valid = '0;
      wait_for("done1", 1, 5000);
      n = 0;
      wr_seen = 1'b0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
         if (uart_wr) wr_seen = 1'b1;
      end
      check("holdoff_len", 32'(n), HOLD);
      check("holdoff_wr_low", 32'(wr_seen), 0);
      for (int i = 0; i < 10; i++) frame_exp[i] = frame_ref[i][0];
      check("txd_frame", 32'(last_frame), 32'(frame_exp));
      check("done_once", 32'(done_cnt), 1);
      check("no_timeout1", 32'(to_cnt), 0);

      // fairness: all four continuously valid from ptr=0
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expect_grant(0, 8'h10, 1'b1);
      expect_grant(1, 8'h11, 1'b1);
      expect_grant(2, 8'h12, 1'b1);
      expect_grant(3, 8'h13, 1'b1);
      expect_grant(0, 8'h10, 1'b1);
      req_data = 32'h1312_1110;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) wait_for("rr_ack", 0, 3000);
      req_valid = '0;
      wait_for("rr_idle", 2, 3000);

      // stuck uart: timeout after 2048 clk in WAIT_BUSY, next grant goes to 2
      manual = 1'b1;
      man_tbe = 1'b1;
      d0 = done_cnt;
      t0 = to_cnt;
      expect_grant(1, 8'h3C, 1'b0);
      req_data = 32'h00C3_3C00;
      req_valid = 4'b0010;
      wait_for("tmo_ack", 0, 100);
      req_valid = 4'b0100;
      expect_grant(2, 8'hC3, 1'b1);
      n = 0;
      while (uart_wr && n < 4000) begin
         n++;
         @(negedge clk);
      end
      check("tmo_wr_len", 32'(n), TMO);
      check("tmo_pulse", 32'(timeout_err), 1);
      repeat (3) @(negedge clk);
      check("tmo_count", 32'(to_cnt - t0), 1);
      check("tmo_no_done", 32'(done_cnt - d0), 0);
      manual = 1'b0;
      wait_for("after_tmo_ack", 0, 1000);
      req_valid = '0;
      wait_for("after_tmo_done", 1, 2000);
      wait_for("after_tmo_idle", 2, 2000);

      // pointer wrap: ptr=3, 0101 -> 0 then 2
      expect_grant(0, 8'h5A, 1'b1);
      expect_grant(2, 8'h77, 1'b1);
      req_data = 32'h0077_005A;
      req_valid = 4'b0101;
      wait_for("wrap_ack0", 0, 100);
      wait_for("wrap_ack2", 0, 3000);
      req_valid = '0;
      wait_for("wrap_idle", 2, 3000);

      // reset while in WAIT_DONE
      d0 = done_cnt;
      expect_grant(0, 8'h81, 1'b0);
      req_data = 32'h0000_0081;
      req_valid = 4'b0001;
      wait_for("wd_ack", 0, 100);
      req_valid = '0;
      wait_for("wd_tbe_low", 3, 100);
      repeat (5) @(negedge clk);
      check("wd_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_outputs", 32'({req_ack, uart_data, uart_wr, busy, grant_id, done, timeout_err}), 0);
      repeat (3) @(negedge clk);
      check("arst_no_done", 32'(done_cnt - d0), 0);
      expect_grant(0, 8'h42, 1'b1);
      req_data = 32'h0000_0042;
      req_valid = 4'b0001;
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ack == '0 && n < 10);
      check("post_rst_grant", 32'(req_ack != '0 && n <= 2), 1);
      req_valid = '0;
      wait_for("post_rst_done", 1, 2000);
      wait_for("post_rst_idle", 2, 2000);

      // synchronizer: 1-clk low glitch in WAIT_BUSY is seen
      manual = 1'b1;
      man_tbe = 1'b1;
      d0 = done_cnt;
      t0 = to_cnt;
      expect_grant(0, 8'hE7, 1'b0);
      req_data = 32'h0000_00E7;
      req_valid = 4'b0001;
      wait_for("gl_ack", 0, 100);
      req_valid = '0;
      repeat (3) @(negedge clk);
      man_tbe = 1'b0;
      @(negedge clk);
      man_tbe = 1'b1;
      wait_for("gl_done", 1, 20);
      check("gl_no_timeout", 32'(to_cnt - t0), 0);
      wait_for("gl_idle", 2, 1000);

      // sub-clk tbe pulse in WAIT_DONE is ignored
      man_tbe = 1'b0;
      expect_grant(0, 8'h18, 1'b0);
      req_data = 32'h0000_0018;
      req_valid = 4'b0001;
      wait_for("sp_ack", 0, 100);
      req_valid = '0;
      repeat (10) @(negedge clk);
      d0 = done_cnt;
      #1 man_tbe = 1'b1;
      #3 man_tbe = 1'b0;
      repeat (10) @(negedge clk);
      check("sp_still_busy", 32'({busy, uart_wr}), 32'h3);
      check("sp_no_done", 32'(done_cnt - d0), 0);
      man_tbe = 1'b1;
      wait_for("sp_done", 1, 20);
      wait_for("sp_idle", 2, 1000);
      manual = 1'b0;

      repeat (5) @(negedge clk);
      check("gnt_queue_empty", 32'(exp_gnt.size()), 0);
      check("rx_queue_empty", 32'(exp_rx.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single `uart` transmitter among NREQ byte producers, e.g. a console, a debug dump and a status reporter.
- Picks one requester round-robin, accepts its byte, and sequences the uart's level-sensitive wr/tbe handshake.
- After each transfer, holds wr low long enough for the uart's slow internal tx clock to return the uart to IDLE.
- Sits between the producer logic and the `uart` instance on the Nexys2 top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLDOFF_CYCLES, 440, clk cycles wr stays low after a transfer; must be at least one uart txclk period (2*(217+1)=436 at 50 MHz/115200).
- TIMEOUT_CYCLES, 2048, max clk cycles to wait for tbe to fall after wr rises.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte pending; level signal, held until accepted.
- req_data  in  8*NREQ  byte of requester i, in bits [8i+7:8i].
- req_ack  out  NREQ  one-clk pulse; requester i's byte has been accepted.
- uart_data  out  8  to uart data_in.
- uart_wr  out  1  to uart wr.
- uart_tbe  in  1  from uart tbe; driven from the uart txclk domain, so treated as asynchronous.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester.
- done  out  1  one-clk pulse when a byte has been fully sent.
- timeout_err  out  1  one-clk pulse when the WAIT_BUSY timeout fires.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - req_ack=0, uart_data=0, uart_wr=0, busy=0, grant_id=0, done=0, timeout_err=0.
  - Round-robin pointer=0, state=IDLE, counter=0, tbe synchronizer=2'b11.
- uart_tbe passes through a 2-flop synchronizer; tbe_s is its output. All decisions use tbe_s only.
- States are one-hot: IDLE, WAIT_BUSY, WAIT_DONE, HOLDOFF.
- IDLE:
  - Leaves IDLE only if some req_valid is high.
  - Winner = first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - On the same clk edge: uart_data<=req_data[winner], req_ack[winner]<=1 for one cycle, grant_id<=winner, uart_wr<=1, counter<=0, go to WAIT_BUSY.
  - A byte is offered to the uart 1 clk after req_valid is seen.
- WAIT_BUSY:
  - uart_data and uart_wr are held stable; the counter increments each clk.
  - tbe_s==0: go to WAIT_DONE.
  - Otherwise, counter==TIMEOUT_CYCLES-1: uart_wr<=0, timeout_err pulse, counter<=0, go to HOLDOFF (no done pulse).
- WAIT_DONE:
  - uart_wr is held at 1 and uart_data is held stable.
  - tbe_s==1: uart_wr<=0, done pulse, counter<=0, go to HOLDOFF.
  - No timeout in this state; a frame is about 4.4k clk long.
- HOLDOFF:
  - uart_wr=0; the counter increments.
  - counter==HOLDOFF_CYCLES-1: ptr<=(grant_id+1) mod NREQ, go to IDLE.
  - req_valid is ignored throughout HOLDOFF.
- Requester rules:
  - req_valid deasserting before ack is legal; it is simply not granted.
  - req_data is sampled only in the IDLE grant cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- A requester may re-present a new byte in the cycle after its ack. It waits for its next round-robin turn.
- Counter: 12 bits. Both count parameters must fit in it; enforce with an elaboration-time check.
- Reset mid-transfer: all outputs go to reset values immediately and uart_wr drops. The uart completes or idles on its own; the next grant is delayed by no extra rule beyond HOLDOFF not being re-run after reset. This is documented as a known limitation.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding constants (one-hot, 4 bits, same style as the uart state machine).
  - Constants UART_TXDIV=217 and UART_CLK_HZ=50_000_000.
  - The derived HOLDOFF minimum.
- One natural sub-module, `rr_arbiter`: combinational round-robin priority pick.
  - Inputs: req[NREQ], ptr.
  - Outputs: gnt_idx, any.
  - Reusable for a future RX-side distributor.

Test Plan:
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 → req_ack=4'b0100 one cycle after; uart_data=8'hA5, uart_wr=1. The uart model shows txd frame 0,1,0,1,0,0,1,0,1,1 (LSB first). done pulses once; wr stays 0 for 440 clk; busy=0 after.
- All four valid continuously with data 8'h10..8'h13 → grant_id order 0,1,2,3,0. Transmitted bytes 10,11,12,13,10. No grant ever occurs in HOLDOFF.
- Stuck uart (uart_tbe tied 1), req_valid[1]=1 → uart_wr drops after exactly 2048 clk in WAIT_BUSY. timeout_err pulses once, no done. The next grant is to requester 2 if it is valid.
- Pointer wrap: ptr=3 after granting 2; req_valid=4'b0101 → grant requester 0. Then with req_valid=4'b0101 still set → grant 2.
- Reset assertion in WAIT_DONE → all outputs 0 within the same cycle (async). After release with req_valid=4'b0001 → grant 0 two cycles after release.
- Synchronizer: a 1-clk glitch low on uart_tbe in WAIT_BUSY aligned between clk edges still registers via tbe_s. A tbe pulse shorter than one clk does not cause a state change in WAIT_DONE.
